// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, RGB pixel type and sync/blank bundle
// used by the VGA timing block and the render logic around it.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam int RGB_W = 12;
  typedef logic [RGB_W-1:0] rgb_t;

  // One pixel's worth of pin-side control, carried through the alignment pipe.
  typedef struct packed {
    logic hs;
    logic vs;
    logic vid;
  } sync_t;

  function automatic logic in_window(input logic [9:0] v,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Clock-enable divider: a one-clk p_tick every CLK_DIV system clocks,
// shared by every block that updates at pixel rate.
module pixel_tick_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick_q;

  always_comb begin
    div_d = div_q + DW'(1);
    if (div_q == DIV_LAST) div_d = '0;
  end

  // The tick is registered so it is exactly one clk wide and glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= (div_q == DIV_LAST);
    end
  end

  assign p_tick = tick_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel/line counters, coordinates for the renderer, and
// a sync/blank delay line so colour and sync reach the connector together.
module vga_timing #(
  parameter int   CLK_DIV     = 4,
  parameter int   H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int   H_FP        = vga_pkg::H_FP,
  parameter int   H_SYNC      = vga_pkg::H_SYNC,
  parameter int   H_BP        = vga_pkg::H_BP,
  parameter int   V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int   V_FP        = vga_pkg::V_FP,
  parameter int   V_SYNC      = vga_pkg::V_SYNC,
  parameter int   V_BP        = vga_pkg::V_BP,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   RENDER_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] rgb_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        p_tick,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] vga_rgb
);
  import vga_pkg::*;

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam sync_t SYNC_IDLE = '{hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE, vid: 1'b0};

  logic       tick;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [9:0] x_q, y_q;
  logic       vid_q, frame_q, hs_q, vs_q;
  rgb_t       rgb_q;
  sync_t      sync_now, pipe_out;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (tick)
  );

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  always_comb begin
    sync_now.hs  = in_window(h_q, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    sync_now.vs  = in_window(v_q, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    sync_now.vid = (h_q < H_VIS) && (v_q < V_VIS);
  end

  // Delay sync/blank by the renderer's latency so they meet its colour.
  if (RENDER_LAT == 0) begin : g_bypass
    assign pipe_out = sync_now;
  end else begin : g_pipe
    sync_t pipe_q [RENDER_LAT];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < RENDER_LAT; i++) pipe_q[i] <= SYNC_IDLE;
      end else if (tick) begin
        pipe_q[0] <= sync_now;
        for (int i = 1; i < RENDER_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign pipe_out = pipe_q[RENDER_LAT-1];
  end

  // Coordinates present the pre-increment count; colour is masked in blanking.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      vid_q   <= 1'b0;
      frame_q <= 1'b0;
      hs_q    <= ~SYNC_ACTIVE;
      vs_q    <= ~SYNC_ACTIVE;
      rgb_q   <= '0;
    end else begin
      frame_q <= 1'b0;
      if (tick) begin
        h_q     <= h_d;
        v_q     <= v_d;
        x_q     <= h_q;
        y_q     <= v_q;
        vid_q   <= sync_now.vid;
        frame_q <= (h_q == H_LAST) && (v_q == V_LAST);
        hs_q    <= pipe_out.hs;
        vs_q    <= pipe_out.vs;
        rgb_q   <= pipe_out.vid ? rgb_t'(rgb_in) : '0;
      end
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign video_on   = vid_q;
  assign p_tick     = tick;
  assign frame_tick = frame_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign vga_rgb    = rgb_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: full-size line timing, plus shrunken rasters
// for whole-frame, mid-frame reset, CLK_DIV=2 and RENDER_LAT 0/1/3 alignment.
module tb_vga_timing;

  typedef struct {
    int hT, vT, hA, vA, hs0, hs1, vs0, vs1, div, rl;
  } cfg_t;

  typedef struct {
    int   x, y;
    logic vid, hs, vs;
  } pix_t;

  typedef struct {
    logic [9:0]  x, y;
    logic        vid, pt, ft, hs, vs;
    logic [11:0] rgb;
  } smp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [11:0] rgbA, rgbB, rgbC, rgbOA, rgbOB, rgbOC;
  logic [9:0]  xA, yA, xB, yB, xC, yC;
  logic        vidA, ptA, ftA, hsA, vsA;
  logic        vidB, ptB, ftB, hsB, vsB;
  logic        vidC, ptC, ftC, hsC, vsC;

  int vectors = 0;
  int miscompares = 0;
  int hsLowCnt, vsLowCnt, ftCnt, vidCnt, firstHsX;
  cfg_t cfgA, cfgB, cfgC;

  vga_timing dutA (
    .clk(clk), .reset(reset), .rgb_in(rgbA), .x(xA), .y(yA), .video_on(vidA),
    .p_tick(ptA), .frame_tick(ftA), .hsync(hsA), .vsync(vsA), .vga_rgb(rgbOA)
  );

  vga_timing #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b0), .RENDER_LAT(3)
  ) dutB (
    .clk(clk), .reset(reset), .rgb_in(rgbB), .x(xB), .y(yB), .video_on(vidB),
    .p_tick(ptB), .frame_tick(ftB), .hsync(hsB), .vsync(vsB), .vga_rgb(rgbOB)
  );

  vga_timing #(
    .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b0), .RENDER_LAT(0)
  ) dutC (
    .clk(clk), .reset(reset), .rgb_in(rgbC), .x(xC), .y(yC), .video_on(vidC),
    .p_tick(ptC), .frame_tick(ftC), .hsync(hsC), .vsync(vsC), .vga_rgb(rgbOC)
  );

  function automatic logic [11:0] colour(input logic [9:0] xv, input logic [9:0] yv);
    return {xv[3:0], yv[3:0], 4'hA};
  endfunction

  // Renderer stand-ins: colour for pixel k becomes valid RENDER_LAT ticks after x shows k.
  initial begin : renderA
    logic [11:0] q[$];
    rgbA = 12'hFFF;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        rgbA = 12'hFFF;
      end else if (ptA) begin
        @(posedge clk);
        #1;
        q.push_back(colour(xA, yA));
        if (q.size() == 1) begin
          rgbA = q[0];
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin : renderB
    logic [11:0] q[$];
    rgbB = 12'hFFF;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        rgbB = 12'hFFF;
      end else if (ptB) begin
        @(posedge clk);
        #1;
        q.push_back(colour(xB, yB));
        if (q.size() == 3) begin
          rgbB = q[0];
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic smp_t grab(input int d);
    smp_t s;
    case (d)
      0:       s = '{xA, yA, vidA, ptA, ftA, hsA, vsA, rgbOA};
      1:       s = '{xB, yB, vidB, ptB, ftB, hsB, vsB, rgbOB};
      default: s = '{xC, yC, vidC, ptC, ftC, hsC, vsC, rgbOC};
    endcase
    return s;
  endfunction

  function automatic pix_t pixAt(input int p, input cfg_t c);
    pix_t r;
    if (p < 0) begin
      r = '{0, 0, 1'b0, 1'b1, 1'b1};
    end else begin
      r.x   = p % c.hT;
      r.y   = (p / c.hT) % c.vT;
      r.vid = (r.x < c.hA) && (r.y < c.vA);
      r.hs  = !((r.x >= c.hs0) && (r.x <= c.hs1));
      r.vs  = !((r.y >= c.vs0) && (r.y <= c.vs1));
    end
    return r;
  endfunction

  task automatic applyStimulus(input int holdCycles);
    reset = 1'b1;
    repeat (holdCycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clearCounts();
    hsLowCnt = 0;
    vsLowCnt = 0;
    ftCnt    = 0;
    vidCnt   = 0;
    firstHsX = -1;
  endtask

  task automatic checkResetValues(input int d);
    smp_t s;
    s = grab(d);
    checkOutput("rstX", s.x, 0);
    checkOutput("rstY", s.y, 0);
    checkOutput("rstVideo", s.vid, 0);
    checkOutput("rstPTick", s.pt, 0);
    checkOutput("rstFrame", s.ft, 0);
    checkOutput("rstHsync", s.hs, 1);
    checkOutput("rstVsync", s.vs, 1);
    checkOutput("rstRgb", s.rgb, 0);
  endtask

  // Waits for the next p_tick (bounded) and samples one clk after it.
  task automatic nextTick(input int d, output smp_t s, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      s = grab(d);
    end while (!s.pt && gap < 20);
    if (!s.pt) checkOutput("tickTimeout", 0, 1);
    @(negedge clk);
    s = grab(d);
  endtask

  task automatic scanTicks(input int d, input cfg_t c, input int n);
    smp_t        s;
    pix_t        e, pin;
    int          gap;
    logic [11:0] rgbExp;
    for (int k = 0; k < n; k++) begin
      nextTick(d, s, gap);
      e   = pixAt(k, c);
      pin = pixAt(k - c.rl, c);
      rgbExp = 12'h000;
      if (pin.vid) rgbExp = (c.rl == 0) ? 12'hFFF : colour(10'(pin.x), 10'(pin.y));
      checkOutput("tickGap", gap, (k == 0) ? c.div : c.div - 1);
      checkOutput("pTickWidth", s.pt, 0);
      checkOutput("x", s.x, e.x);
      checkOutput("y", s.y, e.y);
      checkOutput("video", s.vid, e.vid);
      checkOutput("frameTick", s.ft, (e.x == c.hT - 1) && (e.y == c.vT - 1));
      checkOutput("hsync", s.hs, pin.hs);
      checkOutput("vsync", s.vs, pin.vs);
      checkOutput("vgaRgb", s.rgb, rgbExp);
      if (!s.hs) begin
        hsLowCnt++;
        if (firstHsX < 0) firstHsX = int'(s.x);
      end
      if (!s.vs) vsLowCnt++;
      if (s.ft)  ftCnt++;
      if (s.vid) vidCnt++;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    smp_t s;
    int   gap;
    cfgA  = '{800, 525, 640, 480, 656, 751, 490, 491, 4, 1};
    cfgB  = '{15, 8, 8, 4, 10, 12, 5, 6, 2, 3};
    cfgC  = '{15, 8, 8, 4, 10, 12, 5, 6, 4, 0};
    rgbC  = 12'hFFF;
    reset = 1'b1;

    // Held reset: no ticks leak out and every output sits at its reset value.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("heldPtA", ptA, 0);
      checkOutput("heldPtB", ptB, 0);
      checkOutput("heldPtC", ptC, 0);
    end
    checkResetValues(0);
    checkResetValues(1);
    checkResetValues(2);
    reset = 1'b0;

    $display("[TB] full-size line, CLK_DIV=4, RENDER_LAT=1");
    clearCounts();
    scanTicks(0, cfgA, 800);
    checkOutput("lineVideoCount", vidCnt, 640);
    checkOutput("lineHsLowCount", hsLowCnt, 96);
    checkOutput("lineFirstHsLowX", firstHsX, 657);
    checkOutput("lineVsLowCount", vsLowCnt, 0);
    checkOutput("lineFrameTicks", ftCnt, 0);
    nextTick(0, s, gap);
    checkOutput("wrapX", s.x, 0);
    checkOutput("wrapY", s.y, 1);

    $display("[TB] small raster, CLK_DIV=2, RENDER_LAT=3");
    applyStimulus(3);
    clearCounts();
    scanTicks(1, cfgB, 285);
    checkOutput("bFrameTicks", ftCnt, 2);
    checkOutput("bVsLowCount", vsLowCnt, 60);
    checkOutput("bHsLowCount", hsLowCnt, 56);
    checkOutput("bFirstHsLowX", firstHsX, 13);
    checkOutput("bVideoCount", vidCnt, 88);
    checkOutput("preRstX", xB, 14);
    checkOutput("preRstY", yB, 2);
    checkOutput("preRstHsync", hsB, 0);

    $display("[TB] mid-frame reset with hsync asserted");
    reset = 1'b1;
    @(negedge clk);
    checkResetValues(1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clearCounts();
    scanTicks(1, cfgB, 20);

    $display("[TB] small raster, CLK_DIV=4, RENDER_LAT=0");
    applyStimulus(3);
    clearCounts();
    scanTicks(2, cfgC, 125);
    checkOutput("cFrameTicks", ftCnt, 1);
    checkOutput("cVsLowCount", vsLowCnt, 30);
    checkOutput("cHsLowCount", hsLowCnt, 24);
    checkOutput("cFirstHsLowX", firstHsX, 10);
    checkOutput("cVideoCount", vidCnt, 37);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Supplies the pixel coordinates `x`, `y` and `video_on` that the render stage consumes.
- Accepts the render stage's registered 12-bit RGB back and drives the VGA pins (`hsync`, `vsync`, `vga_rgb`).
- Delays sync and blanking to match render latency, so colour and sync reach the connector aligned.

Parameters:
- CLK_DIV, 4: system clocks per pixel; 100 MHz gives 25 MHz. Legal range is 2 or more, so render always gets at least one clk edge per pixel.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_ACTIVE, 0: asserted level of `hsync`/`vsync`; 0 means active-low.
- RENDER_LAT, 1: pixel ticks between the `x`/`y` update and valid `rgb_in`. Legal range 0..3.

Ports:
- clk, in, 1: system clock, 100 MHz.
- reset, in, 1: synchronous, active-high reset.
- rgb_in, in, 12: RGB from render, laid out {R[11:8], G[7:4], B[3:0]}.
- x, out, 10: current horizontal pixel count, 0..799.
- y, out, 10: current line count, 0..524.
- video_on, out, 1: high when x < H_ACTIVE and y < V_ACTIVE (undelayed).
- p_tick, out, 1: one-clk pixel enable, pulses every CLK_DIV clks.
- frame_tick, out, 1: one-clk pulse when the last pixel of a frame (799,524) is presented.
- hsync, out, 1: horizontal sync pin, delayed by RENDER_LAT.
- vsync, out, 1: vertical sync pin, delayed by RENDER_LAT.
- vga_rgb, out, 12: RGB pin, forced to 0 during blanking.

Behaviour:
- Totals: H_TOTAL = 800 and V_TOTAL = 525 (sums of the parameters). All counters are 10 bits and unsigned.
- Divider: `div` counts 0..CLK_DIV-1 and wraps. `p_tick` = (div == CLK_DIV-1), registered so it is exactly one clk wide.
- Counters advance on `p_tick` only:
  - `h` increments and wraps from H_TOTAL-1 to 0.
  - `v` increments only when `h` wraps, and wraps from V_TOTAL-1 to 0.
- Outputs `x`, `y`, `video_on` are registered and load on `p_tick` from the pre-increment `h`/`v` and their decode. They therefore change one clk after `p_tick`'s edge and are stable for CLK_DIV clks.
- `frame_tick` is registered alongside them and is high for one clk when (x,y) becomes (799,524).
- Sync decode, while the delayed pixel sits in the window:
  - hsync is at SYNC_ACTIVE for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
  - vsync is at SYNC_ACTIVE for v in [490, 491].
  - Otherwise both are at !SYNC_ACTIVE.
- Alignment pipe: a RENDER_LAT-deep shift register of {hsync, vsync, video_on} advances on `p_tick`.
  - On `p_tick`, `vga_rgb` loads `rgb_in` if the pipe's output `video_on` is 1, else 0.
  - `hsync`/`vsync` load from the pipe output on the same tick.
  - RENDER_LAT = 0 bypasses the pipe; `rgb_in` is then sampled on the same tick.
- Net alignment: the pin outputs for pixel k appear RENDER_LAT ticks after `x`/`y` show pixel k.
- Reset (synchronous, active-high, any cycle including mid-frame):
  - `div`, `h`, `v` are 0.
  - `x` = 0, `y` = 0, `video_on` = 0, `frame_tick` = 0, `p_tick` = 0.
  - The pipe is filled with {!SYNC_ACTIVE, !SYNC_ACTIVE, 0}.
  - `hsync` = `vsync` = !SYNC_ACTIVE and `vga_rgb` = 0.
- After reset release: the first `p_tick` occurs CLK_DIV clks later, and at it `x`/`y` present (0,0) with `video_on` = 1.
- Reset held: all outputs stay at reset values, with no partial ticks.
- Out-of-range `rgb_in` cannot leak: any nonzero `rgb_in` during blanking is masked to 0.

Decomposition:
- Package `vga_pkg` holds:
  - the 640x480 timing constants and the derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - the 12-bit RGB width constant and a `rgb_t` typedef.
- Sub-module `pixel_tick_gen` is the CLK_DIV clock-enable divider with the same clk/reset. It is reused by paddle and ball logic for pixel-rate updates.

Test Plan:
- Reset, then release: `p_tick` first pulses 4 clks after release. At it, (x,y) = (0,0) and `video_on` = 1. `hsync` = `vsync` = 1 and `vga_rgb` = 0 until the first aligned tick.
- One full line: `x` goes 0..799, `video_on` is 1 for x = 0..639, `hsync` is low for exactly 96 ticks, and the first low tick lands RENDER_LAT ticks after x = 656.
- Full frame: `vsync` is low for 2 lines (1600 ticks). `frame_tick` pulses once per 800*525*4 = 1,680,000 clks and coincides with (799,524).
- Alignment: drive `rgb_in` = {x[3:0], y[3:0], 4'hA} one clk after each x update. Check `vga_rgb` = colour for pixel k exactly RENDER_LAT ticks later, and 0 at x = 640..799 and y = 480..524. Run with RENDER_LAT = 0, 1 and 3.
- Reset mid-frame at (x,y) = (700,300) with `hsync` low: the next clk gives all reset values and `hsync` = 1. The frame restarts at (0,0) CLK_DIV clks after release.
- CLK_DIV = 2 override: `p_tick` every 2 clks, and all line/frame counts are unchanged in ticks.
